mem_port_arbiter: RTL and testbench

//  Shares one RAM port pair (rd/wr) between two requesters: port 0 = execution

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares a single RAM read/write port pair between two requesters
//            (port 0 = execution unit, port 1 = debug/program loader) using a
//            per-port req/gnt handshake with round-robin resolution when both
//            ask at once. One access is in flight at a time.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            reqN/weN/addrN/wdataN - requester command, held until gntN
//            gntN                  - 1-cycle pulse, command is on the RAM port
//            rvalidN, rdata        - read result pulse per port, shared data
//            busy                  - high while an access is in progress
//            mem_rd_*/mem_wr_*     - RAM port (read data 1 cycle after rd_en)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0] wdata0,
  input  logic [DATA_BITS-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 busy,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_rd_addr,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  output logic                 mem_wr_en,
  output logic [ADDR_BITS-1:0] mem_wr_addr,
  output logic [DATA_BITS-1:0] mem_wr_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state;

  logic r_owner;
  logic w_owner;
  logic r_last_owner;
  logic w_last_owner;
  logic r_we;
  logic w_we;

  // Next values of the registered outputs. Every output is a flop, so the
  // command pulse is computed one cycle early (while IDLE samples the
  // request) and appears on the pins during CMD.
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_rvalid0;
  logic                 w_rvalid1;
  logic                 w_busy;
  logic                 w_rd_en;
  logic                 w_wr_en;
  logic [DATA_BITS-1:0] w_rdata;
  logic [ADDR_BITS-1:0] w_rd_addr;
  logic [ADDR_BITS-1:0] w_wr_addr;
  logic [DATA_BITS-1:0] w_wr_data;

  // Request selection. A lone requester always wins; on contention the port
  // that did not win the previous contention gets the access.
  logic                 w_winner;
  logic                 w_sel_we;
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic [DATA_BITS-1:0] w_sel_wdata;

  assign w_winner    = (req0 && req1) ? ~r_last_owner : req1;
  assign w_sel_we    = w_winner ? we1    : we0;
  assign w_sel_addr  = w_winner ? addr1  : addr0;
  assign w_sel_wdata = w_winner ? wdata1 : wdata0;

  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_last_owner = r_last_owner;
    w_we         = r_we;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_rvalid0    = 1'b0;
    w_rvalid1    = 1'b0;
    w_busy       = 1'b0;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_rdata      = rdata;
    w_rd_addr    = mem_rd_addr;
    w_wr_addr    = mem_wr_addr;
    w_wr_data    = mem_wr_data;

    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_state = CMD;
          w_owner = w_winner;
          w_we    = w_sel_we;
          w_busy  = 1'b1;
          w_gnt0  = ~w_winner;
          w_gnt1  = w_winner;
          if (req0 && req1) begin
            w_last_owner = w_winner;
          end
          if (w_sel_we) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_sel_addr;
            w_wr_data = w_sel_wdata;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_sel_addr;
          end
        end
      end

      // The command is on the RAM port during this cycle; a write is done
      // once the edge ends it, a read still has to collect its data.
      CMD: begin
        w_state = r_we ? IDLE : RESP;
        w_busy  = ~r_we;
      end

      // RAM read data is valid in this cycle; capture it and flag the owner.
      RESP: begin
        w_state   = IDLE;
        w_rdata   = mem_rd_data;
        w_rvalid0 = ~r_owner;
        w_rvalid1 = r_owner;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_we         <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      mem_rd_en    <= 1'b0;
      mem_rd_addr  <= '0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_last_owner <= w_last_owner;
      r_we         <= w_we;
      gnt0         <= w_gnt0;
      gnt1         <= w_gnt1;
      rvalid0      <= w_rvalid0;
      rvalid1      <= w_rvalid1;
      busy         <= w_busy;
      rdata        <= w_rdata;
      mem_rd_en    <= w_rd_en;
      mem_rd_addr  <= w_rd_addr;
      mem_wr_en    <= w_wr_en;
      mem_wr_addr  <= w_wr_addr;
      mem_wr_data  <= w_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios for
//            reset, single-port write/read, contention, a request arriving
//            during a read response and a dropped pulse, followed by random
//            two-port traffic scored against a transaction-level model.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       we0 = 1'b0;
  logic       we1 = 1'b0;
  logic [7:0] addr0 = 8'h00;
  logic [7:0] addr1 = 8'h00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic       gnt0;
  logic       gnt1;
  logic       rvalid0;
  logic       rvalid1;
  logic [7:0] rdata;
  logic       busy;
  logic       mem_rd_en;
  logic [7:0] mem_rd_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic       mem_wr_en;
  logic [7:0] mem_wr_addr;
  logic [7:0] mem_wr_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  mem_port_arbiter #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a * 8'd7 + 8'd3) ^ 8'h5A;
  endfunction

  // Synchronous RAM attached to the arbiter: read data one cycle after rd_en.
  logic [7:0] ram [256];
  logic       ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
      ram_ready <= 1'b1;
    end else begin
      if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy, mem_rd_en, mem_wr_en, rdata,
         mem_rd_addr, mem_wr_addr, mem_wr_data} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_state: outputs=%h required 0", {gnt0, gnt1, rvalid0, rvalid1,
               busy, mem_rd_en, mem_wr_en, rdata, mem_rd_addr, mem_wr_addr, mem_wr_data});
    end
    reset = 1'b0;
    req0  = 1'b1;
    we0   = 1'b0;
    addr0 = 8'h20;
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1 || mem_rd_en !== 1'b1 || mem_rd_addr !== 8'h20) begin
      n_fail++;
      $display("FAIL reset_setup_read: gnt0=%b rd_en=%b rd_addr=%h required 1 1 20",
               gnt0, mem_rd_en, mem_rd_addr);
    end
    req0 = 1'b0;
    tick();                       // now in the read response cycle
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, mem_rd_en, mem_wr_en, rdata,
           mem_rd_addr, mem_wr_addr, mem_wr_data} !== 39'h0) begin
        n_fail++;
        $display("FAIL reset_mid_read[%0d]: outputs=%h required 0", i, {gnt0, gnt1,
                 rvalid0, rvalid1, busy, mem_rd_en, mem_wr_en, rdata, mem_rd_addr,
                 mem_wr_addr, mem_wr_data});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, mem_rd_en, mem_wr_en} !== 7'h0) begin
        n_fail++;
        $display("FAIL reset_no_late_pulse[%0d]: flags=%b required 0", i,
                 {gnt0, gnt1, rvalid0, rvalid1, busy, mem_rd_en, mem_wr_en});
      end
    end
  endtask

  task automatic test_write_p0();
    req0   = 1'b1;
    we0    = 1'b1;
    addr0  = 8'h10;
    wdata0 = 8'hA5;
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 ||
        mem_wr_addr !== 8'h10 || mem_wr_data !== 8'hA5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_p0_cmd: gnt0=%b gnt1=%b wr_en=%b rd_en=%b addr=%h data=%h busy=%b required 1 0 1 0 10 a5 1",
               gnt0, gnt1, mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data, busy);
    end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || gnt0 !== 1'b0 || mem_wr_en !== 1'b0 ||
        mem_wr_addr !== 8'h10 || mem_wr_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_p0_done: busy=%b gnt0=%b wr_en=%b addr=%h data=%h required 0 0 0 10 a5",
               busy, gnt0, mem_wr_en, mem_wr_addr, mem_wr_data);
    end
  endtask

  task automatic test_read_p1();
    req1  = 1'b1;
    we1   = 1'b0;
    addr1 = 8'h10;
    tick();
    n_cmp++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_rd_en !== 1'b1 || mem_rd_addr !== 8'h10 ||
        mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL read_p1_cmd: gnt1=%b gnt0=%b rd_en=%b rd_addr=%h wr_en=%b required 1 0 1 10 0",
               gnt1, gnt0, mem_rd_en, mem_rd_addr, mem_wr_en);
    end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || rvalid1 !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL read_p1_resp: busy=%b rvalid1=%b rd_en=%b required 1 0 0",
               busy, rvalid1, mem_rd_en);
    end
    tick();
    n_cmp++;
    if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 8'hA5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL read_p1_data: rvalid1=%b rvalid0=%b rdata=%h busy=%b required 1 0 a5 0",
               rvalid1, rvalid0, rdata, busy);
    end
    tick();
    n_cmp++;
    if (rvalid1 !== 1'b0 || rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_p1_hold: rvalid1=%b rdata=%h required 0 a5", rvalid1, rdata);
    end
  endtask

  task automatic test_both_held();
    int   g0;
    int   g1;
    logic exp_port;
    g0       = 0;
    g1       = 0;
    exp_port = 1'b0;
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    req0   = 1'b1;
    we0    = 1'b1;
    addr0  = 8'h30;
    wdata0 = 8'h77;
    req1   = 1'b1;
    we1    = 1'b0;
    addr1  = 8'h31;
    // Port 0 writes (2 cycles) and port 1 reads (3 cycles) alternate, so 40
    // cycles hold 8 grants for each port.
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++;
      if (gnt0 && gnt1) begin
        n_fail++;
        $display("FAIL rr_coincide: gnt0=%b gnt1=%b at cycle %0d required not both", gnt0, gnt1, i);
      end
      if (gnt0 || gnt1) begin
        n_cmp++;
        if (gnt1 !== exp_port) begin
          n_fail++;
          $display("FAIL rr_order: granted port %0d required port %0d", gnt1, exp_port);
        end
        exp_port = ~exp_port;
        if (gnt0) g0++;
        if (gnt1) g1++;
      end
      if (rvalid1) begin
        n_cmp++;
        if (rdata !== init_val(8'h31)) begin
          n_fail++;
          $display("FAIL rr_read_data: rdata=%h required %h", rdata, init_val(8'h31));
        end
      end
    end
    n_cmp++;
    if (g0 != 8 || g1 != 8) begin
      n_fail++;
      $display("FAIL rr_counts: gnt0 x%0d gnt1 x%0d required 8 and 8", g0, g1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_req_during_resp();
    req0  = 1'b1;
    we0   = 1'b0;
    addr0 = 8'h40;
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_req_gnt0: gnt0=%b required 1", gnt0);
    end
    req0 = 1'b0;
    tick();                       // response cycle of port 0 read
    req1   = 1'b1;
    we1    = 1'b1;
    addr1  = 8'h40;
    wdata1 = 8'h3C;
    tick();
    n_cmp++;
    if (rvalid0 !== 1'b1 || rdata !== init_val(8'h40) || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_req_idle: rvalid0=%b rdata=%h gnt1=%b required 1 %h 0",
               rvalid0, rdata, gnt1, init_val(8'h40));
    end
    tick();
    n_cmp++;
    if (gnt1 !== 1'b1 || mem_wr_en !== 1'b1 || mem_wr_addr !== 8'h40 || mem_wr_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL resp_req_gnt1: gnt1=%b wr_en=%b addr=%h data=%h required 1 1 40 3c",
               gnt1, mem_wr_en, mem_wr_addr, mem_wr_data);
    end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if (rdata !== init_val(8'h40) || rvalid0 !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_req_after: rdata=%h rvalid0=%b busy=%b required %h 0 0",
               rdata, rvalid0, busy, init_val(8'h40));
    end
  endtask

  task automatic test_pulse_while_busy();
    logic saw_g0;
    logic saw_wr;
    logic saw_rv1;
    saw_g0  = 1'b0;
    saw_wr  = 1'b0;
    saw_rv1 = 1'b0;
    req1  = 1'b1;
    we1   = 1'b0;
    addr1 = 8'h50;
    tick();
    req1   = 1'b0;
    req0   = 1'b1;
    we0    = 1'b1;
    addr0  = 8'h51;
    wdata0 = 8'hEE;
    tick();
    req0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt0) saw_g0 = 1'b1;
      if (mem_wr_en) saw_wr = 1'b1;
      if (rvalid1) begin
        saw_rv1 = 1'b1;
        n_cmp++;
        if (rdata !== init_val(8'h50)) begin
          n_fail++;
          $display("FAIL pulse_read_data: rdata=%h required %h", rdata, init_val(8'h50));
        end
      end
    end
    n_cmp++;
    if (saw_g0 !== 1'b0 || saw_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_dropped: gnt0 seen=%b wr_en seen=%b required 0 0", saw_g0, saw_wr);
    end
    n_cmp++;
    if (saw_rv1 !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_rvalid1: seen=%b required 1", saw_rv1);
    end
  endtask

  // Transaction-level expectation tables indexed by cycle number.
  logic [1:0] m_g   [4096];        // 0 none, 1 port0, 2 port1 granted
  logic [1:0] m_rv  [4096];        // 0 none, 1 port0, 2 port1 read result
  logic       m_busy[4096];
  logic       m_wr  [4096];
  logic       m_rd  [4096];
  logic [7:0] m_wa  [4096];
  logic [7:0] m_wd  [4096];
  logic [7:0] m_ra  [4096];
  logic [7:0] m_rvd [4096];
  logic [7:0] ref_mem [256];

  task automatic test_random();
    int         free_at;
    int         e;
    logic       last;
    logic       w;
    logic [7:0] a;
    logic [7:0] h_wa;
    logic [7:0] h_wd;
    logic [7:0] h_ra;
    logic [7:0] h_rd;
    logic [38:0] exp_v;
    logic [38:0] got_v;
    for (int i = 0; i < 4096; i++) begin
      m_g[i] = 2'd0; m_rv[i] = 2'd0; m_busy[i] = 1'b0; m_wr[i] = 1'b0; m_rd[i] = 1'b0;
      m_wa[i] = 8'h0; m_wd[i] = 8'h0; m_ra[i] = 8'h0; m_rvd[i] = 8'h0;
    end
    for (int i = 128; i < 256; i++) ref_mem[i] = init_val(8'(i));
    h_wa = 8'h0; h_wd = 8'h0; h_ra = 8'h0; h_rd = 8'h0;
    req0  = 1'b0;
    req1  = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    free_at = cyc + 1;
    last    = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      // Requesters: drop on grant, occasionally abandon, occasionally start.
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (req0 && $urandom_range(15) == 0) req0 = 1'b0;
      if (req1 && $urandom_range(15) == 0) req1 = 1'b0;
      if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1'b1; we0 = 1'($urandom_range(1));
        addr0 = 8'h80 | 8'($urandom_range(127)); wdata0 = 8'($urandom);
      end
      if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1'b1; we1 = 1'($urandom_range(1));
        addr1 = 8'h80 | 8'($urandom_range(127)); wdata1 = 8'($urandom);
      end
      // Model: the arbiter accepts at the next edge if it is free by then.
      e = cyc + 1;
      if (e >= free_at && (req0 || req1) && e + 2 < 4096) begin
        if (req0 && req1) begin
          w    = ~last;
          last = w;
        end else begin
          w = req1;
        end
        a         = w ? addr1 : addr0;
        m_g[e]    = w ? 2'd2 : 2'd1;
        m_busy[e] = 1'b1;
        if (w ? we1 : we0) begin
          m_wr[e]    = 1'b1;
          m_wa[e]    = a;
          m_wd[e]    = w ? wdata1 : wdata0;
          ref_mem[a] = m_wd[e];
          free_at    = e + 2;
        end else begin
          m_rd[e]       = 1'b1;
          m_ra[e]       = a;
          m_busy[e + 1] = 1'b1;
          m_rv[e + 2]   = w ? 2'd2 : 2'd1;
          m_rvd[e + 2]  = ref_mem[a];
          free_at       = e + 3;
        end
      end
      tick();
      if (m_wr[cyc]) begin
        h_wa = m_wa[cyc];
        h_wd = m_wd[cyc];
      end
      if (m_rd[cyc]) h_ra = m_ra[cyc];
      if (m_rv[cyc] != 2'd0) h_rd = m_rvd[cyc];
      exp_v = {m_g[cyc] == 2'd1, m_g[cyc] == 2'd2, m_rv[cyc] == 2'd1, m_rv[cyc] == 2'd2,
               m_busy[cyc], m_wr[cyc], m_rd[cyc], h_wa, h_wd, h_ra, h_rd};
      got_v = {gnt0, gnt1, rvalid0, rvalid1, busy, mem_wr_en, mem_rd_en,
               mem_wr_addr, mem_wr_data, mem_rd_addr, rdata};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc=%0d: outputs=%h required %h", cyc, got_v, exp_v);
      end
      n_cmp++;
      if ((gnt0 && gnt1) || (mem_rd_en && mem_wr_en)) begin
        n_fail++;
        $display("FAIL random_exclusive cyc=%0d: gnt=%b%b en=%b%b required no overlap",
                 cyc, gnt0, gnt1, mem_rd_en, mem_wr_en);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_read_p1();
    test_both_held();
    test_req_during_resp();
    test_pulse_while_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
